dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter READ_LAT, default 1, DataMem read latency in cycles (legal 1..4).
REQ-004 The block SHALL have port clka, input, 1, single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rsta, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have ports p0_req / p1_req, input, 1, access request from requester 0 (CPU load/store) and requester 1 (loader/debug).
REQ-007 The block SHALL have ports p0_we / p1_we, input, 1, 1 = write, 0 = read.
REQ-008 The block SHALL have ports p0_addr / p1_addr, input, ADDR_W, word address.
REQ-009 The block SHALL have ports p0_wdata / p1_wdata, input, DATA_W, write data.
REQ-010 The block SHALL have ports p0_gnt / p1_gnt, output, 1, request accepted this cycle.
REQ-011 The block SHALL have ports p0_rvalid / p1_rvalid, output, 1, read data valid for that requester.
REQ-012 The block SHALL have ports p0_rdata / p1_rdata, output, DATA_W, read data.
REQ-013 The block SHALL have ports mem_wea [0:0], mem_addra [ADDR_W-1:0], mem_dina [DATA_W-1:0], output, driving the DataMem port.
REQ-014 The block SHALL have port mem_douta, input, DATA_W, DataMem read data.
REQ-015 The block SHALL have port mem_rsta, output, 1, equal to rsta.

Function
REQ-016 Grant SHALL be combinational in the request cycle: at most one of p0_gnt/p1_gnt high per cycle; a requester holds req/we/addr/wdata stable until it sees gnt.
REQ-017 A single requester SHALL be granted immediately.
REQ-018 With both requesting, the port that was not granted most recently SHALL win (round-robin; last_grant register updates only on a grant).
REQ-019 The granted port's addr/wdata SHALL drive mem_addra/mem_dina, and mem_wea SHALL equal its we AND gnt; with no grant, mem_wea SHALL be 0 and mem_addra/mem_dina SHALL hold their previous values.
REQ-020 A granted read in cycle N SHALL raise the owner's rvalid for exactly one cycle at cycle N+READ_LAT, with rdata = mem_douta in that cycle.
REQ-021 Reads SHALL be fully pipelined: one grant per cycle, with owners tracked in a READ_LAT-deep tag shift register (valid bit + port id).
REQ-022 Writes SHALL complete in the grant cycle and never produce rvalid.
REQ-023 Outside its rvalid cycle, rdata SHALL be 0.
REQ-024 Read-after-write to the same address by either port SHALL return the written data (grant order defines memory order).

Reset
REQ-025 While rsta is high: gnt outputs 0, rvalid outputs 0, rdata 0, mem_wea 0, mem_addra 0, mem_dina 0, tag pipeline cleared, last_grant = 1 (port 0 wins first conflict).
REQ-026 Reads in flight when rsta asserts SHALL be discarded; no rvalid for them after reset release.
REQ-027 The first grant after reset SHALL be possible in the first clock edge after rsta deasserts.

Structure
REQ-028 ADDR_W/DATA_W defaults and the port-id encoding (PORT_CPU=0, PORT_AUX=1) SHALL live in a shared constants include used by the datapath.
REQ-029 The READ_LAT tag pipeline SHALL be one sub-module, rd_tag_pipe; arbitration logic SHALL be inline.

Verification
REQ-030 p0 write addr 2 data 0x5, then p1 read addr 2 -> p1_rvalid one cycle after p1 grant, p1_rdata = 0x00000005, p0_rvalid stays 0.
REQ-031 After reset, both request reads (addr 1, addr 4) in the same cycle -> p0_gnt that cycle, p1_gnt next cycle, rvalid follows each grant after READ_LAT cycles.
REQ-032 Both request continuously for 8 cycles -> grants alternate 0,1,0,1,... with no idle cycle.
REQ-033 p0 read addr 2 granted, rsta pulsed in the next cycle -> p0_rvalid never asserts; all outputs 0 during reset.
REQ-034 READ_LAT=2 with back-to-back reads p0 addr 1, p1 addr 2, p0 addr 4 -> three rvalids on consecutive cycles, each routed to the correct port with the correct data.
REQ-035 No requests -> mem_wea stays 0 and all gnt/rvalid stay 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared constants for the data-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   port_e                  : requester id (PORT_CPU = 0, PORT_AUX = 1)
//   rd_tag_t                : one read-tag slot (valid bit + owning port)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// READ_LAT-deep shift register that follows each granted read through the
// DataMem latency so the returning data can be steered to its owner.
// Ports:
//   clka   : clock
//   rsta   : asynchronous active-high reset, flushes every in-flight tag
//   i_tag  : tag entering in the grant cycle (vld = granted read)
//   o_tag  : tag whose data is on mem_douta this cycle
// -----------------------------------------------------------------------------
module rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic    clka,
  input  logic    rsta,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_tag_p [READ_LAT];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_tag_p[i] <= '0;
      end
    end else begin
      r_tag_p[0] <= i_tag;
      for (int i = 1; i < READ_LAT; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign o_tag = r_tag_p[READ_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port round-robin arbiter in front of a single-port DataMem.
// Grant is combinational in the request cycle; the granted port drives the
// memory port directly. Reads return READ_LAT cycles later on the owner's
// rvalid/rdata; writes complete in the grant cycle.
// Parameters:
//   ADDR_W   : word-address width
//   DATA_W   : data width
//   READ_LAT : DataMem read latency in cycles (legal range 1..4)
// Ports:
//   clka, rsta                        : clock, async active-high reset
//   pN_req/pN_we/pN_addr/pN_wdata     : requester N command (held until gnt)
//   pN_gnt                            : requester N accepted this cycle
//   pN_rvalid/pN_rdata                : read return for requester N
//   mem_wea/mem_addra/mem_dina        : DataMem command
//   mem_douta                         : DataMem read data
//   mem_rsta                          : DataMem reset (mirrors rsta)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [0:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              mem_rsta
);

  port_e             r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any_gnt;
  port_e             w_gnt_port;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  rd_tag_t           w_tag_in;
  rd_tag_t           w_tag_out;

  // Arbitration: on conflict the port that did not win last time goes first.
  // Grants are forced low while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rsta) begin
      if (p0_req && (!p1_req || r_last_grant == PORT_AUX)) begin
        w_gnt0 = 1'b1;
      end else if (p1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_gnt_port = w_gnt1 ? PORT_AUX : PORT_CPU;
  assign w_we       = w_gnt1 ? p1_we    : p0_we;
  assign w_addr     = w_gnt1 ? p1_addr  : p0_addr;
  assign w_wdata    = w_gnt1 ? p1_wdata : p0_wdata;

  assign p0_gnt = w_gnt0;
  assign p1_gnt = w_gnt1;

  // last_grant and the held memory command only move on a grant
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_last_grant <= PORT_AUX;
      r_addr       <= '0;
      r_din        <= '0;
    end else if (w_any_gnt) begin
      r_last_grant <= w_gnt_port;
      r_addr       <= w_addr;
      r_din        <= w_wdata;
    end
  end

  // The memory samples its command on the grant edge, so the granted command
  // is forwarded combinationally; idle cycles replay the last command with
  // the write strobe low.
  assign mem_wea   = w_any_gnt & w_we;
  assign mem_addra = w_any_gnt ? w_addr  : r_addr;
  assign mem_dina  = w_any_gnt ? w_wdata : r_din;
  assign mem_rsta  = rsta;

  assign w_tag_in = '{vld: w_any_gnt & ~w_we, port: w_gnt_port};

  rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_tag_pipe (
    .clka  (clka),
    .rsta  (rsta),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign p0_rvalid = w_tag_out.vld && (w_tag_out.port == PORT_CPU);
  assign p1_rvalid = w_tag_out.vld && (w_tag_out.port == PORT_AUX);
  assign p0_rdata  = p0_rvalid ? mem_douta : '0;
  assign p1_rdata  = p1_rvalid ? mem_douta : '0;

endmodule
